mant_align: RTL

//  Mantissa alignment stage of the fp32 adder; sits directly downstream of the 8-bit exponent comparator.
//  - Takes the comparator's a_lt_b/abs_diff plus both operands' sign/exponent/mantissa.
//  - Swaps so the larger-exponent operand is "big"; shifts the small mantissa right by abs_diff.
//  - Produces guard/round/sticky bits; 2-stage valid/ready pipeline.

---
 rtl/mant_align_pkg.sv | 20 ++
 rtl/mant_align_rsh_sticky.sv | 23 ++
 rtl/mant_align.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mant_align_pkg.sv
// Shared constants for the fp32 mantissa alignment stage.
// Build option: ALIGN_STICKY_EN enables guard/round/sticky generation.
package mant_align_pkg;

    localparam int MW_DEF = 24;
    localparam int EW_DEF = 8;
    localparam int GRS_W  = 3;
    localparam int PAD_W  = 3;

`ifdef ALIGN_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    function automatic int ext_w(input int mw);
        return mw + PAD_W;
    endfunction

endpackage

// File: rtl/mant_align_rsh_sticky.sv
// Combinational right shifter that also reports whether any set bit fell off the end.
// Sticky output is forced to 0 unless ALIGN_STICKY_EN is defined.
module rsh_sticky
    import mant_align_pkg::*;
#(
    parameter real T  = 0.0,
    parameter int  W  = 27,
    parameter int  SW = 8
) (
    input  logic [W-1:0]  data,
    input  logic [SW-1:0] amt,
    output logic [W-1:0]  data_out,
    output logic          sticky_out
);

    logic [W-1:0] lost_mask;

    assign data_out   = data >> amt;
    // Amounts >= W make the mask all ones, so every input bit counts as lost.
    assign lost_mask  = ~({W{1'b1}} << amt);
    assign sticky_out = STICKY_EN & (|(data & lost_mask));

endmodule

// File: rtl/mant_align.sv
// fp32 adder mantissa alignment: operand swap, two-stage right shift, guard/round/sticky.
// Build option: ALIGN_STICKY_EN (undefined -> grs tied to 0, plain truncating shift).
module mant_align
    import mant_align_pkg::*;
#(
    parameter real T  = 0.0,
    parameter int  MW = MW_DEF,
    parameter int  EW = EW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          a_lt_b,
    input  logic [EW-1:0] abs_diff,
    input  logic          sign_a,
    input  logic          sign_b,
    input  logic [EW-1:0] exp_a,
    input  logic [EW-1:0] exp_b,
    input  logic [MW-1:0] man_a,
    input  logic [MW-1:0] man_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sign_big,
    output logic          sign_small,
    output logic [EW-1:0] exp_big,
    output logic [MW-1:0] man_big,
    output logic [MW-1:0] man_small,
    output logic [2:0]    grs
);

    localparam int XW = ext_w(MW);

    logic s1_en, s2_en;

    // Stage 1 state
    logic          s1_v_q,         s1_v_d;
    logic          s1_sign_big_q,  s1_sign_big_d;
    logic          s1_sign_sml_q,  s1_sign_sml_d;
    logic [EW-1:0] s1_exp_big_q,   s1_exp_big_d;
    logic [MW-1:0] s1_man_big_q,   s1_man_big_d;
    logic [XW-1:0] s1_ext_q,       s1_ext_d;
    logic          s1_stk_q,       s1_stk_d;
    logic [2:0]    s1_fine_q,      s1_fine_d;

    // Stage 2 (output) state
    logic          out_valid_q,    out_valid_d;
    logic          sign_big_q,     sign_big_d;
    logic          sign_small_q,   sign_small_d;
    logic [EW-1:0] exp_big_q,      exp_big_d;
    logic [MW-1:0] man_big_q,      man_big_d;
    logic [MW-1:0] man_small_q,    man_small_d;
    logic [2:0]    grs_q,          grs_d;

    logic [MW-1:0] man_sml_in;
    logic [EW-1:0] coarse_amt;
    logic [XW-1:0] ext_c, ext_f;
    logic          stk_c, stk_f, stk_all;

    assign s2_en    = ~out_valid_q | out_ready;
    assign s1_en    = ~s1_v_q | s2_en;
    assign in_ready = s1_en;

    assign man_sml_in = a_lt_b ? man_a : man_b;
    assign coarse_amt = {abs_diff[EW-1:3], 3'b000};

    rsh_sticky #(.T(T), .W(XW), .SW(EW)) u_coarse (
        .data       ({man_sml_in, {PAD_W{1'b0}}}),
        .amt        (coarse_amt),
        .data_out   (ext_c),
        .sticky_out (stk_c)
    );

    rsh_sticky #(.T(T), .W(XW), .SW(3)) u_fine (
        .data       (s1_ext_q),
        .amt        (s1_fine_q),
        .data_out   (ext_f),
        .sticky_out (stk_f)
    );

    assign stk_all = s1_stk_q | stk_f | (STICKY_EN & ext_f[0]);

    always_comb begin
        s1_v_d        = s1_v_q;
        s1_sign_big_d = s1_sign_big_q;
        s1_sign_sml_d = s1_sign_sml_q;
        s1_exp_big_d  = s1_exp_big_q;
        s1_man_big_d  = s1_man_big_q;
        s1_ext_d      = s1_ext_q;
        s1_stk_d      = s1_stk_q;
        s1_fine_d     = s1_fine_q;
        if (s1_en) begin
            s1_v_d = in_valid;
            // Equal exponents keep a as the big operand.
            if (in_valid) begin
                s1_sign_big_d = a_lt_b ? sign_b : sign_a;
                s1_sign_sml_d = a_lt_b ? sign_a : sign_b;
                s1_exp_big_d  = a_lt_b ? exp_b  : exp_a;
                s1_man_big_d  = a_lt_b ? man_b  : man_a;
                s1_ext_d      = ext_c;
                s1_stk_d      = stk_c;
                s1_fine_d     = abs_diff[2:0];
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        exp_big_d    = exp_big_q;
        man_big_d    = man_big_q;
        man_small_d  = man_small_q;
        grs_d        = grs_q;
        if (s2_en) begin
            out_valid_d = s1_v_q;
            if (s1_v_q) begin
                sign_big_d   = s1_sign_big_q;
                sign_small_d = s1_sign_sml_q;
                exp_big_d    = s1_exp_big_q;
                man_big_d    = s1_man_big_q;
                man_small_d  = ext_f[XW-1:PAD_W];
                grs_d        = STICKY_EN ? {ext_f[2], ext_f[1], stk_all} : 3'b000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q        <= 1'b0;
            s1_sign_big_q <= 1'b0;
            s1_sign_sml_q <= 1'b0;
            s1_exp_big_q  <= '0;
            s1_man_big_q  <= '0;
            s1_ext_q      <= '0;
            s1_stk_q      <= 1'b0;
            s1_fine_q     <= '0;
            out_valid_q   <= 1'b0;
            sign_big_q    <= 1'b0;
            sign_small_q  <= 1'b0;
            exp_big_q     <= '0;
            man_big_q     <= '0;
            man_small_q   <= '0;
            grs_q         <= '0;
        end else begin
            s1_v_q        <= s1_v_d;
            s1_sign_big_q <= s1_sign_big_d;
            s1_sign_sml_q <= s1_sign_sml_d;
            s1_exp_big_q  <= s1_exp_big_d;
            s1_man_big_q  <= s1_man_big_d;
            s1_ext_q      <= s1_ext_d;
            s1_stk_q      <= s1_stk_d;
            s1_fine_q     <= s1_fine_d;
            out_valid_q   <= out_valid_d;
            sign_big_q    <= sign_big_d;
            sign_small_q  <= sign_small_d;
            exp_big_q     <= exp_big_d;
            man_big_q     <= man_big_d;
            man_small_q   <= man_small_d;
            grs_q         <= grs_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign sign_big   = sign_big_q;
    assign sign_small = sign_small_q;
    assign exp_big    = exp_big_q;
    assign man_big    = man_big_q;
    assign man_small  = man_small_q;
    assign grs        = grs_q;

endmodule
